uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter AW, default 4: address width; depth = 2**AW entries (16).
REQ-002 SHALL have parameter THRESH, default 8: fill level that asserts thresh_irq (range 1..2**AW).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port din  input  8  received byte from the UART receiver data output.
REQ-006 SHALL have port din_valid  input  1  one-cycle strobe from the receiver ready output; din is valid in this cycle.
REQ-007 SHALL have port rd  input  1  host pop strobe, one byte per asserted cycle.
REQ-008 SHALL have port dout  output  8  head-of-queue byte (first-word-fall-through).
REQ-009 SHALL have port empty  output  1  queue holds 0 bytes.
REQ-010 SHALL have port full  output  1  queue holds 2**AW bytes.
REQ-011 SHALL have port count  output  AW+1  current fill level, 0..2**AW.
REQ-012 SHALL have port overrun  output  1  sticky flag: a byte was dropped.
REQ-013 SHALL have port clr_ovr  input  1  clears overrun.
REQ-014 SHALL have port thresh_irq  output  1  fill-level interrupt (see Configuration).

Function
REQ-015 SHALL store din at wr_ptr and increment wr_ptr and count on a cycle with din_valid=1 and full=0.
REQ-016 SHALL pop on a cycle with rd=1 and empty=0: increment rd_ptr, decrement count; rd while empty is ignored with no state change.
REQ-017 SHALL drive dout = mem[rd_ptr] combinationally while empty=0, and 8'h00 while empty=1; a written byte is visible on dout one cycle after its din_valid.
REQ-018 SHALL wrap wr_ptr and rd_ptr modulo 2**AW; count is not wrapped and is never above 2**AW.
REQ-019 SHALL derive empty and full as registered flags consistent with count (empty = count==0, full = count==2**AW) in the same cycle.
REQ-020 SHALL, with din_valid=1 and rd=1 while 0<count<2**AW, perform both operations and leave count unchanged.
REQ-021 SHALL, with din_valid=1 and rd=1 while full=1, pop the head and accept the new byte; count remains 2**AW and overrun is not set.
REQ-022 SHALL, with din_valid=1 and rd=1 while empty=1, accept the write, ignore the read, and set count to 1.
REQ-023 SHALL, with din_valid=1, rd=0 and full=1, discard din, keep memory and pointers unchanged, and set overrun on the next edge.
REQ-024 SHALL clear overrun on clr_ovr=1; if an overrun event occurs in the same cycle, set SHALL win.
REQ-025 SHALL not alter stored bytes except by writes.

Reset
REQ-026 SHALL, on a clock edge with reset=0, set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, and thresh_irq=0; memory contents are not reset.
REQ-027 SHALL give reset priority over din_valid, rd and clr_ovr; a reset mid-stream discards all queued bytes, and dout reads 8'h00 from the following cycle.

Configuration
REQ-028 SHALL compile threshold interrupt logic only when macro UART_RX_FIFO_THRESH_EN is defined.
REQ-029 SHALL, with UART_RX_FIFO_THRESH_EN defined, register thresh_irq = (count_next >= THRESH) | overrun_next, so it updates in the same edge as count.
REQ-030 SHALL, without UART_RX_FIFO_THRESH_EN, tie thresh_irq to 0 and remove the comparator; all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset, write 8'hA5 then 8'h3C, pop twice -> dout 8'hA5 one cycle after the first write, then 8'h3C, then 8'h00 with empty=1 and count=0.
REQ-032 SHALL cover: 16 writes of 8'h00..8'h0F, then a 17th write of 8'hFF -> full=1, count=16, overrun=1 next cycle; the 16 pops return 8'h00..8'h0F and 8'hFF is never seen.
REQ-033 SHALL cover: full queue, din_valid and rd in the same cycle with din=8'h77 -> count stays 16, overrun stays 0, and 8'h77 is popped last.
REQ-034 SHALL cover: overrun=1, clr_ovr together with another dropped write -> overrun stays 1; clr_ovr alone next cycle -> overrun=0.
REQ-035 SHALL cover: 40 write/pop pairs to exercise pointer wrap, then reset=0 asserted with count=5 -> count=0, empty=1, and dout=8'h00 next cycle.
REQ-036 SHALL cover: with UART_RX_FIFO_THRESH_EN and THRESH=8, thresh_irq rises on the edge count goes 7->8 and falls on 8->7; the same bench without the macro sees thresh_irq=0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte queue between a UART receiver and a host. Bytes arrive
//   as one-cycle din_valid strobes. The host pops one byte per asserted rd
//   cycle. dout is first-word-fall-through: it shows the head byte without a
//   pop, and reads 8'h00 while the queue is empty.
//
//   Parameters
//     AW      : address width; depth = 2**AW entries
//     THRESH  : fill level that raises thresh_irq (1..2**AW)
//
//   Ports
//     clk        in   system clock, rising edge
//     reset      in   synchronous reset, active low
//     din        in   received byte
//     din_valid  in   din strobe
//     rd         in   host pop strobe
//     dout       out  head-of-queue byte, 8'h00 when empty
//     empty      out  queue holds 0 bytes
//     full       out  queue holds 2**AW bytes
//     count      out  fill level, 0..2**AW
//     overrun    out  sticky: a byte was dropped because the queue was full
//     clr_ovr    in   clears overrun (a same-cycle drop wins)
//     thresh_irq out  fill-level interrupt
//
//   Build option
//     UART_RX_FIFO_THRESH_EN : when defined, thresh_irq is registered as
//     (count_next >= THRESH) | overrun_next. When undefined, thresh_irq is
//     tied low and the comparator is not built.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    din,
  input  logic          din_valid,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic          thresh_irq
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overrun_q, overrun_d;

  logic          wr_en;
  logic          rd_en;
  logic          drop;

  // A write into a full queue is still accepted when a pop happens in the
  // same cycle: the head leaves as the new byte lands in the freed slot.
  // A read against an empty queue is simply ignored, so a simultaneous
  // write and read on an empty queue only writes.
  always_comb begin
    rd_en = rd && !empty_q;
    wr_en = din_valid && (!full_q || rd);
    drop  = din_valid && full_q && !rd;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);

    // Drop has priority over clear so a same-cycle loss is never hidden.
    overrun_d = overrun_q;
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not cleared by reset, but a write strobe during reset must not
  // disturb it either.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    dout = 8'h00;
    if (!empty_q) begin
      dout = mem_q[rd_ptr_q];
    end
  end

  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

  logic thresh_q;
  logic thresh_d;

  // Built from next-state values so the interrupt moves on the same edge as
  // count and overrun.
  always_comb begin
    thresh_d = (count_d >= THRESH_C) || overrun_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      thresh_q <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
    end
  end

  assign thresh_irq = thresh_q;
`else
  assign thresh_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int AW     = 4;
  localparam int THRESH = 8;
  localparam int DEPTH  = 16;
`ifdef UART_RX_FIFO_THRESH_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    din;
  logic          din_valid;
  logic          rd;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          clr_ovr;
  logic          thresh_irq;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mdl_count = 0;
  bit            mdl_ovr   = 1'b0;
  logic [7:0]    exp_q[$];

  uart_rx_fifo #(.AW(AW), .THRESH(THRESH)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .rd         (rd),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .thresh_irq (thresh_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (reset === 1'b1 && rd === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: dout=%02h, no byte was expected", dout);
      end else begin
        logic [7:0] eb;
        eb = exp_q.pop_front();
        chk("pop_data", dout, eb);
      end
    end
  end

  task automatic check_state();
    logic exp_thr;
    exp_thr = THR_EN && ((mdl_count >= THRESH) || mdl_ovr);
    chk("count",      count,      mdl_count);
    chk("empty",      empty,      mdl_count == 0);
    chk("full",       full,       mdl_count == DEPTH);
    chk("overrun",    overrun,    mdl_ovr);
    chk("thresh_irq", thresh_irq, exp_thr);
    if (mdl_count == 0) chk("dout_empty", dout, 8'h00);
    else                chk("dout_head",  dout, exp_q[0]);
  endtask

  // One cycle of stimulus, applied just after a rising edge.
  task automatic step(input logic dv, input logic [7:0] d, input logic r, input logic c);
    logic rd_acc, wr_acc, drp;
    rd_acc = r && (mdl_count != 0);
    wr_acc = dv && ((mdl_count != DEPTH) || r);
    drp    = dv && (mdl_count == DEPTH) && !r;
    din_valid = dv;
    din       = d;
    rd        = r;
    clr_ovr   = c;
    if (wr_acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 8'h00;
    rd        = 1'b0;
    clr_ovr   = 1'b0;
    mdl_count = mdl_count + int'(wr_acc) - int'(rd_acc);
    if (drp)    mdl_ovr = 1'b1;
    else if (c) mdl_ovr = 1'b0;
    check_state();
  endtask

  initial begin
    reset = 1'b0; din = 8'h00; din_valid = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",   count,      0);
    chk("rst_empty",   empty,      1);
    chk("rst_full",    full,       0);
    chk("rst_overrun", overrun,    0);
    chk("rst_thresh",  thresh_irq, 0);
    chk("rst_dout",    dout,       8'h00);
    reset = 1'b1;

    // Basic write / FWFT / pop
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("dout_after_first_write", dout, 8'hA5);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("dout_second", dout, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_dout",  dout,  8'h00);
    chk("drained_empty", empty, 1);
    chk("drained_count", count, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);  // pop while empty: ignored
    chk("rd_empty_count", count, 0);

    // Fill to full, then a dropped write
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full",  full,    1);
    chk("fill_count", count,   16);
    chk("fill_ovr",   overrun, 0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop_ovr",   overrun, 1);
    chk("drop_count", count,   16);
    chk("drop_head",  dout,    8'h00);

    // Clear racing a drop: set wins; then clear alone
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_vs_drop_ovr", overrun, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone_ovr", overrun, 0);

    // Full queue, simultaneous write and pop
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw_count", count,   16);
    chk("full_rw_ovr",   overrun, 0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("after_drain_queue", exp_q.size(), 0);

    // Simultaneous write and read on empty queue: write only
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_rw_count", count, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 40 write/pop pairs to wrap both pointers
    for (int i = 0; i < 40; i++) step(1'b1, 8'(i * 7 + 3), (mdl_count != 0), 1'b0);
    for (int i = 0; i < 4; i++)  step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("pre_reset_count", count, 5);

    // Reset with traffic present: reset wins
    reset = 1'b0; din_valid = 1'b1; din = 8'h99; rd = 1'b1; clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1; din_valid = 1'b0; din = 8'h00; rd = 1'b0; clr_ovr = 1'b0;
    exp_q.delete();
    mdl_count = 0;
    mdl_ovr   = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_dout",  dout,  8'h00);
    check_state();

    // Threshold crossing 7->8 and 8->7
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("thr_at_7", thresh_irq, 0);
    step(1'b1, 8'h47, 1'b0, 1'b0);
    chk("thr_at_8", thresh_irq, THR_EN);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("thr_back_7", thresh_irq, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_queue", exp_q.size(), 0);
    chk("final_empty", empty, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
